// File: rtl/gold_miner_pkg.sv
// Shared screen geometry, coordinate widths and draw-engine state encoding
// for the gold miner display path.
package gold_miner_pkg;

  localparam int unsigned SCREEN_W = 320;
  localparam int unsigned SCREEN_H = 240;
  localparam int unsigned X_W      = 9;
  localparam int unsigned Y_W      = 8;
  localparam int unsigned COLOUR_W = 9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StScan  = 2'd1,
    StDrain = 2'd2,
    StDone  = 2'd3
  } draw_state_e;

endpackage

// File: rtl/sprite_scan_counter.sv
// Row-major dx/dy/address walker over an OBJ_W x OBJ_H sprite box.
module sprite_scan_counter #(
  parameter int unsigned OBJ_W = 16,
  parameter int unsigned OBJ_H = 16,
  localparam int unsigned DX_W = (OBJ_W > 1) ? $clog2(OBJ_W) : 1,
  localparam int unsigned DY_W = (OBJ_H > 1) ? $clog2(OBJ_H) : 1,
  localparam int unsigned AW   = (OBJ_W * OBJ_H > 1) ? $clog2(OBJ_W * OBJ_H) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            clear,
  input  logic            advance,
  output logic [DX_W-1:0] dx,
  output logic [DY_W-1:0] dy,
  output logic [AW-1:0]   addr,
  output logic            last
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dx   <= '0;
      dy   <= '0;
      addr <= '0;
    end else if (clear) begin
      dx   <= '0;
      dy   <= '0;
      addr <= '0;
    end else if (advance) begin
      addr <= addr + AW'(1);
      if (dx == DX_W'(OBJ_W - 1)) begin
        dx <= '0;
        dy <= (dy == DY_W'(OBJ_H - 1)) ? '0 : dy + DY_W'(1);
      end else begin
        dx <= dx + DX_W'(1);
      end
    end
  end

  assign last = (addr == AW'(OBJ_W * OBJ_H - 1));

endmodule

// File: rtl/draw_object_engine.sv
// Scans a sprite box one pixel per cycle through a 2-stage pipeline
// (address -> ROM/coordinates -> VGA write port) and pulses done at the end.
module draw_object_engine
  import gold_miner_pkg::*;
#(
  parameter int unsigned          OBJ_W       = 16,
  parameter int unsigned          OBJ_H       = 16,
  parameter int unsigned          COLOUR_W    = gold_miner_pkg::COLOUR_W,
  parameter logic [COLOUR_W-1:0]  TRANSPARENT = 9'h1F8,
  localparam int unsigned         AW = (OBJ_W * OBJ_H > 1) ? $clog2(OBJ_W * OBJ_H) : 1
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                start_draw,
  input  logic [X_W-1:0]      x_start,
  input  logic [Y_W-1:0]      y_start,
  input  logic                erase,
  input  logic [COLOUR_W-1:0] bg_colour,
  output logic [AW-1:0]       sprite_addr,
  input  logic [COLOUR_W-1:0] sprite_colour,
  output logic [X_W-1:0]      plot_x,
  output logic [Y_W-1:0]      plot_y,
  output logic [COLOUR_W-1:0] plot_colour,
  output logic                plot_en,
  output logic                busy,
  output logic                draw_object_done
);

  localparam int unsigned DX_W = (OBJ_W > 1) ? $clog2(OBJ_W) : 1;
  localparam int unsigned DY_W = (OBJ_H > 1) ? $clog2(OBJ_H) : 1;

  draw_state_e   state_q;
  logic [X_W-1:0] x0_q;
  logic [Y_W-1:0] y0_q;
  logic           erase_q;
  logic           drain_q;

  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;
  logic            last;
  logic            cnt_clear;
  logic            cnt_advance;

  // Stage 1: one extra bit so boxes hanging off the screen edge compare correctly.
  logic           v1_q;
  logic [X_W:0]   px_q;
  logic [Y_W:0]   py_q;

  assign cnt_clear   = (state_q == StIdle) && start_draw;
  assign cnt_advance = (state_q == StScan);

  sprite_scan_counter #(
    .OBJ_W (OBJ_W),
    .OBJ_H (OBJ_H)
  ) u_scan (
    .clk     (clk),
    .resetn  (resetn),
    .clear   (cnt_clear),
    .advance (cnt_advance),
    .dx      (dx),
    .dy      (dy),
    .addr    (sprite_addr),
    .last    (last)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= StIdle;
      x0_q             <= '0;
      y0_q             <= '0;
      erase_q          <= 1'b0;
      drain_q          <= 1'b0;
      busy             <= 1'b0;
      draw_object_done <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_draw) begin
            x0_q    <= x_start;
            y0_q    <= y_start;
            erase_q <= erase;
            busy    <= 1'b1;
            state_q <= StScan;
          end
        end
        StScan: begin
          if (last) begin
            drain_q <= 1'b0;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          drain_q <= 1'b1;
          if (drain_q) begin
            draw_object_done <= 1'b1;
            state_q          <= StDone;
          end
        end
        StDone: begin
          draw_object_done <= 1'b0;
          busy             <= 1'b0;
          state_q          <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      v1_q        <= 1'b0;
      px_q        <= '0;
      py_q        <= '0;
      plot_x      <= '0;
      plot_y      <= '0;
      plot_colour <= '0;
      plot_en     <= 1'b0;
    end else begin
      v1_q        <= (state_q == StScan);
      px_q        <= {1'b0, x0_q} + (X_W + 1)'(dx);
      py_q        <= {1'b0, y0_q} + (Y_W + 1)'(dy);
      // sprite_colour lines up with stage-1 coordinates here.
      plot_x      <= px_q[X_W-1:0];
      plot_y      <= py_q[Y_W-1:0];
      plot_colour <= erase_q ? bg_colour : sprite_colour;
      plot_en     <= v1_q && (px_q < (X_W + 1)'(SCREEN_W)) && (py_q < (Y_W + 1)'(SCREEN_H))
                     && (erase_q || (sprite_colour != TRANSPARENT));
    end
  end

endmodule

// File: tb/tb_draw_object_engine.sv
// Directed bench for draw_object_engine with a behavioural 1-cycle sprite ROM.
module tb_draw_object_engine;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start_draw;
  logic [8:0] x_start;
  logic [7:0] y_start;
  logic       erase;
  logic [8:0] bg_colour;
  logic [7:0] sprite_addr;
  logic [8:0] sprite_colour;
  logic [8:0] plot_x;
  logic [7:0] plot_y;
  logic [8:0] plot_colour;
  logic       plot_en;
  logic       busy;
  logic       draw_object_done;

  int n_cmp = 0;
  int n_bad = 0;
  int rom_mode = 0;
  int fx, fy, fc, lx, ly, lc;

  always #5 clk = ~clk;

  draw_object_engine u_dut (
    .clk              (clk),
    .resetn           (resetn),
    .start_draw       (start_draw),
    .x_start          (x_start),
    .y_start          (y_start),
    .erase            (erase),
    .bg_colour        (bg_colour),
    .sprite_addr      (sprite_addr),
    .sprite_colour    (sprite_colour),
    .plot_x           (plot_x),
    .plot_y           (plot_y),
    .plot_colour      (plot_colour),
    .plot_en          (plot_en),
    .busy             (busy),
    .draw_object_done (draw_object_done)
  );

  // Mode 1 makes every even address transparent.
  function automatic logic [8:0] rom_val(input logic [7:0] a);
    if (rom_mode == 1 && !a[0]) return 9'h1F8;
    return {1'b0, a};
  endfunction

  always @(posedge clk) sprite_colour <= rom_val(sprite_addr);

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a negedge; start is accepted on the next posedge (cycle T-1 -> T).
  task automatic run_draw(input string name, input int x, input int y, input bit er,
                          input bit hold, input int exp_writes, input int abort_k);
    int writes = 0, bad = 0, dones = 0, done_k = -1;
    fx = -1; fy = -1; fc = -1; lx = -1; ly = -1; lc = -1;
    x_start = 9'(x); y_start = 8'(y); erase = er; start_draw = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 259; k++) begin
      int px, py, n;
      logic [8:0] col;
      bit en, exp_busy;
      @(negedge clk);
      if (k == 0 && !hold) start_draw = 1'b0;
      if (k == abort_k) begin
        check({name, "_pre_rst_plot_en"}, int'(plot_en), 1);
        resetn = 1'b0;
        #1;
        check({name, "_rst_plot_en"}, int'(plot_en), 0);
        check({name, "_rst_busy"}, int'(busy), 0);
        check({name, "_rst_done"}, int'(draw_object_done), 0);
        return;
      end
      if (k == 100) begin
        x_start = 9'(x + 77); y_start = 8'(y + 33); erase = ~er;
      end
      en = 1'b0; px = 0; py = 0; col = '0;
      if (k >= 2 && k <= 257) begin
        n   = k - 2;
        px  = x + n % 16;
        py  = y + n / 16;
        col = er ? bg_colour : rom_val(8'(n));
        en  = (px < 320) && (py < 240) && (er || col != 9'h1F8);
      end
      if (plot_en !== en) bad++;
      else if (en && (plot_x !== 9'(px) || plot_y !== 8'(py) || plot_colour !== col)) bad++;
      exp_busy = (k <= 258);
      if (busy !== exp_busy) bad++;
      if (plot_en) begin
        writes++;
        if (fx < 0) begin fx = plot_x; fy = plot_y; fc = plot_colour; end
        lx = plot_x; ly = plot_y; lc = plot_colour;
      end
      if (draw_object_done) begin dones++; done_k = k; end
    end
    check({name, "_writes"}, writes, exp_writes);
    check({name, "_done_cycle"}, done_k, 258);
    check({name, "_done_pulses"}, dones, 1);
    check({name, "_pixel_errs"}, bad, 0);
  endtask

  initial begin
    resetn = 1'b0; start_draw = 1'b0; x_start = '0; y_start = '0;
    erase = 1'b0; bg_colour = '0;
    repeat (3) @(negedge clk);
    check("reset_plot_en", int'(plot_en), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(draw_object_done), 0);
    check("reset_addr", int'(sprite_addr), 0);
    check("reset_plot_x", int'(plot_x), 0);
    check("reset_plot_colour", int'(plot_colour), 0);
    resetn = 1'b1;
    @(negedge clk);

    rom_mode = 0;
    run_draw("draw", 146, 40, 1'b0, 1'b0, 256, -1);
    check("draw_first_x", fx, 146);
    check("draw_first_y", fy, 40);
    check("draw_first_c", fc, 0);
    check("draw_last_x", lx, 161);
    check("draw_last_y", ly, 55);
    check("draw_last_c", lc, 255);

    bg_colour = 9'h1FF;
    run_draw("erase", 303, 40, 1'b1, 1'b0, 256, -1);
    check("erase_first_x", fx, 303);
    check("erase_last_x", lx, 318);
    check("erase_colour", lc, 511);

    rom_mode = 1;
    run_draw("transp", 146, 40, 1'b0, 1'b0, 128, -1);
    check("transp_first_x", fx, 147);
    check("transp_first_c", fc, 1);

    rom_mode = 0;
    run_draw("clip", 310, 230, 1'b0, 1'b0, 100, -1);
    check("clip_last_x", lx, 319);
    check("clip_last_y", ly, 239);

    run_draw("hs1", 20, 100, 1'b0, 1'b1, 256, -1);
    run_draw("hs2", 40, 120, 1'b0, 1'b1, 256, -1);
    check("hs2_first_x", fx, 40);
    run_draw("hs3", 60, 10, 1'b0, 1'b0, 256, -1);

    run_draw("rst", 146, 40, 1'b0, 1'b0, 0, 50);
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_addr", int'(sprite_addr), 0);
    run_draw("post_rst", 0, 0, 1'b0, 1'b0, 256, -1);
    check("post_rst_first_x", fx, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
